// File: rtl/sram_sprite_fetcher.sv
// Sprite fetcher: streams a width x height SRAM image as x/y-tagged pixels; colour key under SRAM_SPRITE_FETCHER_COLORKEY_EN.
// Latency: first read the cycle after start, first pixel RD_LATENCY+1 cycles after that, o_done two cycles after the last pixel.
// Backpressure: i_pix_ready stalls the pixel stream; reads are credited so in-flight plus buffered words never exceed FIFO_DEPTH.

module sram_sprite_fetcher_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head_dat,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
endmodule

module sram_sprite_fetcher #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int PIXEL_WIDTH = 4,
    parameter int DIM_WIDTH   = 11,
    parameter int RD_LATENCY  = 2,
    parameter int FIFO_DEPTH  = 4
`ifdef SRAM_SPRITE_FETCHER_COLORKEY_EN
    ,
    parameter logic [PIXEL_WIDTH-1:0] COLOR_KEY = '0
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    input  logic [DIM_WIDTH-1:0]   i_width,
    input  logic [DIM_WIDTH-1:0]   i_height,
    output logic                   o_sram_rd,
    output logic [ADDR_WIDTH-1:0]  o_sram_addr,
    input  logic [DATA_WIDTH-1:0]  i_sram_rdata,
    output logic                   o_pix_valid,
    input  logic                   i_pix_ready,
    output logic [PIXEL_WIDTH-1:0] o_pix_data,
    output logic [DIM_WIDTH-1:0]   o_pix_x,
    output logic [DIM_WIDTH-1:0]   o_pix_y,
    output logic                   o_pix_last,
    output logic                   o_busy,
    output logic                   o_done
`ifdef SRAM_SPRITE_FETCHER_COLORKEY_EN
    ,
    input  logic                   i_key_en,
    output logic                   o_pix_transparent
`endif
);
    localparam int PPW = DATA_WIDTH / PIXEL_WIDTH;
    localparam int NW  = 2 * DIM_WIDTH;
    localparam int SW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [DIM_WIDTH-1:0]  r_width;
    logic [DIM_WIDTH-1:0]  r_height;
    logic [DIM_WIDTH-1:0]  r_x;
    logic [DIM_WIDTH-1:0]  r_y;
    logic [NW-1:0]         r_nwords;
    logic [NW-1:0]         r_issued;
    logic [SW-1:0]         r_sub;
    logic [RD_LATENCY-1:0] r_rd_sr;
    logic                  r_busy;
    logic                  r_done;

    logic [NW-1:0]          w_npix_in;
    logic [NW:0]            w_npix_round;
    logic [NW-1:0]          w_nwords_in;
    logic [CW-1:0]          w_inflight;
    logic [CW-1:0]          w_fifo_count;
    logic                   w_fifo_empty;
    logic [DATA_WIDTH-1:0]  w_fifo_head;
    logic                   w_rd;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fire;
    logic                   w_pix_active;
    logic                   w_last;
    logic                   w_sub_end;
    logic [PIXEL_WIDTH-1:0] w_pix;

    assign w_npix_in    = NW'(i_width) * NW'(i_height);
    assign w_npix_round = {1'b0, w_npix_in} + (NW+1)'(PPW - 1);
    assign w_nwords_in  = NW'(w_npix_round / (NW+1)'(PPW));

    // Reads still in the latency pipe count against the same credit pool as buffered words.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_rd_sr[i]);
        end
    end

    assign w_rd   = (r_state == S_FETCH) && ((w_inflight + w_fifo_count) < CW'(FIFO_DEPTH));
    assign w_push = r_rd_sr[RD_LATENCY-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_sr <= '0;
        end else begin
            r_rd_sr[0] <= w_rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_sr[i] <= r_rd_sr[i-1];
            end
        end
    end

    sram_sprite_fetcher_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_push),
        .i_push_dat (i_sram_rdata),
        .i_pop      (w_pop),
        .o_head_dat (w_fifo_head),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    assign w_pix_active = ((r_state == S_FETCH) || (r_state == S_DRAIN)) && !w_fifo_empty;
    assign w_pix        = w_fifo_head[r_sub*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign w_last       = (r_x == r_width - DIM_WIDTH'(1)) && (r_y == r_height - DIM_WIDTH'(1));
    assign w_sub_end    = (r_sub == SW'(PPW - 1));
    assign w_fire       = w_pix_active && i_pix_ready;
    // The final word may be partial; its padding pixels are dropped by popping early.
    assign w_pop        = w_fire && (w_sub_end || w_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_nwords <= '0;
            r_issued <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_sub    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !r_done) begin
                        r_base   <= i_base_addr;
                        r_width  <= i_width;
                        r_height <= i_height;
                        r_nwords <= w_nwords_in;
                        r_issued <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= (w_npix_in == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_rd) begin
                        r_issued <= r_issued + NW'(1);
                        if (r_issued + NW'(1) == r_nwords) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_fire && w_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            if (w_fire) begin
                if (w_last) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (r_x == r_width - DIM_WIDTH'(1)) begin
                    r_x <= '0;
                    r_y <= r_y + DIM_WIDTH'(1);
                end else begin
                    r_x <= r_x + DIM_WIDTH'(1);
                end
                r_sub <= w_pop ? '0 : r_sub + SW'(1);
            end
        end
    end

    assign o_sram_rd   = w_rd;
    assign o_sram_addr = r_base + ADDR_WIDTH'(r_issued);
    assign o_pix_valid = w_pix_active;
    assign o_pix_data  = w_pix_active ? w_pix : '0;
    assign o_pix_x     = r_x;
    assign o_pix_y     = r_y;
    assign o_pix_last  = w_pix_active && w_last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

`ifdef SRAM_SPRITE_FETCHER_COLORKEY_EN
    assign o_pix_transparent = w_pix_active && i_key_en && (w_pix == COLOR_KEY);
`endif
endmodule

// File: tb/tb_sram_sprite_fetcher.sv
// Randomised bench for sram_sprite_fetcher: an SRAM stub with fixed read latency feeds the DUT,
// and a per-pixel model derived from image geometry checks every read and every pixel.
module tb_sram_sprite_fetcher;
    localparam int    PPW = 4;
    localparam longint INF = 64'h3FFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [19:0] i_base_addr = '0;
    logic [10:0] i_width = '0;
    logic [10:0] i_height = '0;
    logic        o_sram_rd;
    logic [19:0] o_sram_addr;
    logic [15:0] sram_rdata;
    logic        o_pix_valid;
    logic        i_pix_ready = 1'b0;
    logic [3:0]  o_pix_data;
    logic [10:0] o_pix_x;
    logic [10:0] o_pix_y;
    logic        o_pix_last;
    logic        o_busy;
    logic        o_done;

    sram_sprite_fetcher dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_width      (i_width),
        .i_height     (i_height),
        .o_sram_rd    (o_sram_rd),
        .o_sram_addr  (o_sram_addr),
        .i_sram_rdata (sram_rdata),
        .o_pix_valid  (o_pix_valid),
        .i_pix_ready  (i_pix_ready),
        .o_pix_data   (o_pix_data),
        .o_pix_x      (o_pix_x),
        .o_pix_y      (o_pix_y),
        .o_pix_last   (o_pix_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_err = 0;
    longint cyc = 0;
    logic [31:0] m_seed = 32'h1234_5678;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sram_word(input logic [19:0] a);
        logic [31:0] h;
        h = ({12'h0, a} * 32'h9E37_79B1) ^ m_seed;
        h = h ^ (h >> 15);
        return h[15:0] ^ h[31:16];
    endfunction

    // SRAM stub: request seen in cycle c is answered during cycle c+2; other cycles carry junk.
    logic        s_rd = 1'b0;
    logic [19:0] s_addr = '0;
    logic        p1_v = 1'b0;
    logic [19:0] p1_a = '0;
    logic [15:0] p_dat = '0;
    always @(negedge clk) begin
        s_rd   = o_sram_rd;
        s_addr = o_sram_addr;
    end
    always @(posedge clk) begin
        p1_v  <= s_rd;
        p1_a  <= s_addr;
        p_dat <= p1_v ? sram_word(p1_a) : 16'($urandom);
    end
    assign sram_rdata = p_dat;

    // Image model
    logic [19:0] m_base = '0;
    int          m_w = 0, m_h = 0, m_npix = 0, m_nwords = 0;
    int          m_rd_cnt = 0, m_pix_cnt = 0, m_done_seen = 0;
    bit          m_active = 1'b0;
    longint      m_start_cyc = INF, m_done_at = INF, m_done_obs = 0;
    logic [19:0] m_rd_log [4];
    logic [19:0] m_last_addr = '0;
    int          m_last_x = 0, m_last_y = 0;
    logic [3:0]  m_last_data = '0;

    function automatic logic [3:0] exp_pix(input int p);
        logic [15:0] w;
        w = sram_word(20'(m_base + 20'(p / PPW)));
        return w[(p % PPW)*4 +: 4];
    endfunction

    function automatic int popped(input int n);
        return n / PPW + ((n == m_npix && (m_npix % PPW) != 0) ? 1 : 0);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", o_busy, (cyc > m_start_cyc) && (cyc < m_done_at));
            check("done", o_done, cyc == m_done_at);
            if (o_done) begin
                m_done_seen++;
                m_done_obs = cyc;
            end
            if (o_sram_rd) begin
                if (!m_active || m_rd_cnt >= m_nwords) begin
                    check("spurious_read", 1, 0);
                end else begin
                    check("rd_addr", o_sram_addr, 20'(m_base + 20'(m_rd_cnt)));
                    check("credit", (m_rd_cnt - popped(m_pix_cnt)) < 4, 1);
                    if (m_rd_cnt < 4) m_rd_log[m_rd_cnt] = o_sram_addr;
                    m_last_addr = o_sram_addr;
                    m_rd_cnt++;
                end
            end
            if (o_pix_valid) begin
                if (!m_active || m_pix_cnt >= m_npix) begin
                    check("spurious_pixel", 1, 0);
                end else begin
                    check("pix_data", o_pix_data, exp_pix(m_pix_cnt));
                    check("pix_x", o_pix_x, m_pix_cnt % m_w);
                    check("pix_y", o_pix_y, m_pix_cnt / m_w);
                    check("pix_last", o_pix_last, m_pix_cnt == m_npix - 1);
                    if (i_pix_ready) begin
                        if (o_pix_last) begin
                            m_last_x    = int'(o_pix_x);
                            m_last_y    = int'(o_pix_y);
                            m_last_data = o_pix_data;
                        end
                        m_pix_cnt++;
                        if (m_pix_cnt == m_npix) m_done_at = cyc + 2;
                    end
                end
            end
        end
    end

    task automatic drive_ready(input int mode, input int k);
        case (mode)
            0:       i_pix_ready = 1'b1;
            1:       i_pix_ready = (k % 3 == 0);
            default: i_pix_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic start_image(input logic [19:0] base, input int w, input int h, input int mode);
        @(posedge clk); #1;
        m_base = base; m_w = w; m_h = h;
        m_npix = w * h; m_nwords = (m_npix + PPW - 1) / PPW;
        m_rd_cnt = 0; m_pix_cnt = 0; m_done_seen = 0; m_done_obs = 0;
        m_last_x = -1; m_last_y = -1;
        m_active = 1'b1;
        m_start_cyc = cyc;
        m_done_at = (m_npix == 0) ? cyc + 2 : INF;
        i_base_addr = base; i_width = 11'(w); i_height = 11'(h); i_start = 1'b1;
        drive_ready(mode, 0);
        @(posedge clk); #1;
        i_start = 1'b0;
        i_base_addr = 20'($urandom); i_width = 11'($urandom); i_height = 11'($urandom);
        drive_ready(mode, 1);
    endtask

    task automatic finish_image(input int mode, input string nm);
        longint limit;
        int     k;
        limit = cyc + longint'(m_npix) * 4 + 64;
        k = 2;
        while (cyc <= m_done_at && cyc < limit) begin
            @(posedge clk); #1;
            drive_ready(mode, k);
            k++;
        end
        check({nm, "_completed"}, cyc > m_done_at, 1);
        check({nm, "_reads"}, m_rd_cnt, m_nwords);
        check({nm, "_pixels"}, m_pix_cnt, m_npix);
        check({nm, "_done_pulses"}, m_done_seen, 1);
    endtask

    task automatic run_image(input logic [19:0] base, input int w, input int h, input int mode, input string nm);
        start_image(base, w, h, mode);
        finish_image(mode, nm);
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_rd"}, o_sram_rd, 0);
        check({nm, "_addr"}, o_sram_addr, 0);
        check({nm, "_valid"}, o_pix_valid, 0);
        check({nm, "_data"}, o_pix_data, 0);
        check({nm, "_x"}, o_pix_x, 0);
        check({nm, "_y"}, o_pix_y, 0);
        check({nm, "_last"}, o_pix_last, 0);
        check({nm, "_busy"}, o_busy, 0);
        check({nm, "_done"}, o_done, 0);
    endtask

    initial begin
        m_seed = $urandom;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Player sprite
        run_image(20'h57E40, 50, 50, 0, "sprite");
        check("sprite_first_addr", m_rd_log[0], 20'h57E40);
        check("sprite_last_addr", m_last_addr, 20'h580B0);
        check("sprite_nreads", m_rd_cnt, 625);
        check("sprite_npix", m_pix_cnt, 2500);
        check("sprite_last_x", m_last_x, 49);
        check("sprite_last_y", m_last_y, 49);
        check("sprite_throughput", (m_done_obs - m_start_cyc) <= 2510, 1);

        // Bullet with partial last word
        run_image(20'($urandom), 25, 25, 2, "bullet");
        check("bullet_nreads", m_rd_cnt, 157);
        check("bullet_npix", m_pix_cnt, 625);
        check("bullet_last_data", m_last_data, sram_word(20'(m_base + 20'd156)) & 16'hF);

        // Backpressure
        run_image(20'($urandom), 8, 2, 1, "stall");

        // Zero size
        run_image(20'($urandom), 0, 7, 0, "zero");
        check("zero_nreads", m_rd_cnt, 0);
        check("zero_done_delay", m_done_obs - m_start_cyc, 2);

        // Address wrap
        run_image(20'hFFFFE, 12, 1, 0, "wrap");
        check("wrap_addr0", m_rd_log[0], 20'hFFFFE);
        check("wrap_addr1", m_rd_log[1], 20'hFFFFF);
        check("wrap_addr2", m_rd_log[2], 20'h00000);

        for (int t = 0; t < 6; t++) begin
            run_image(20'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(1, 12)),
                      int'($urandom_range(0, 2)), "random");
        end

        // Reset mid-image
        begin
            longint lim;
            start_image(20'h57E40, 50, 50, 0);
            lim = cyc + 400;
            while (m_pix_cnt < 100 && cyc < lim) begin
                @(posedge clk); #1;
            end
            check("midreset_reached", m_pix_cnt >= 100, 1);
            #2 rst_n = 1'b0;
            m_active = 1'b0; m_start_cyc = INF; m_done_at = INF;
            #1 check_outputs_zero("midreset");
            @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
            repeat (8) @(posedge clk);
            #1 check("post_reset_idle_busy", o_busy, 0);
            run_image(20'h57E40, 50, 50, 2, "after_reset");
            check("after_reset_last_x", m_last_x, 49);
            check("after_reset_last_y", m_last_y, 49);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog");
    end
endmodule
